// File: rtl/prim_fifo_rd_pkg.sv
// prim_fifo_rd_pkg: shared types and sizing helpers for the FIFO read controller
package prim_fifo_rd_pkg;
  typedef enum logic [1:0] {RdIdle, RdRun, RdFlush} rd_state_e;
  localparam int unsigned SkidDepth = 2;
  function automatic int unsigned vbits(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/prim_fifo_sync_rd_ctrl_if.sv
// prim_fifo_sync_rd_ctrl_if: pointer-counter, storage and downstream stream signals of the read controller
interface prim_fifo_sync_rd_ctrl_if #(
  parameter int unsigned Width  = 8,
  parameter int unsigned PtrW   = 2,
  parameter int unsigned DepthW = 3
);
  logic              clr_i;
  logic              fifo_empty_i;
  logic [DepthW-1:0] fifo_depth_i;
  logic [PtrW-1:0]   fifo_rptr_i;
  logic              fifo_incr_rptr_o;
  logic              mem_rd_en_o;
  logic [PtrW-1:0]   mem_raddr_o;
  logic [Width-1:0]  mem_rdata_i;
  logic              rvalid_o;
  logic              rready_i;
  logic [Width-1:0]  rdata_o;
  logic              lowmark_o;
  logic              err_o;
  modport master (
    input  clr_i, fifo_empty_i, fifo_depth_i, fifo_rptr_i, mem_rdata_i, rready_i,
    output fifo_incr_rptr_o, mem_rd_en_o, mem_raddr_o, rvalid_o, rdata_o, lowmark_o, err_o
  );
  modport slave (
    output clr_i, fifo_empty_i, fifo_depth_i, fifo_rptr_i, mem_rdata_i, rready_i,
    input  fifo_incr_rptr_o, mem_rd_en_o, mem_raddr_o, rvalid_o, rdata_o, lowmark_o, err_o
  );
endinterface

// File: rtl/prim_skid_buf2.sv
// prim_skid_buf2: two-entry FIFO-ordered valid/ready skid buffer
module prim_skid_buf2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             rready_i,
  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic [1:0]       cnt_o
);
  logic [Width-1:0] tail_q;
  logic rd, wr_ok;
  assign rvalid_o = cnt_o != 2'd0;
  assign rd = rvalid_o & rready_i;
  assign wr_ok = wr_i & (rd | cnt_o != 2'd2);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= 2'd0;
      rdata_o <= '0;
      tail_q <= '0;
    end else if (clr_i) begin
      cnt_o <= 2'd0;
    end else begin
      cnt_o <= cnt_o + {1'b0, wr_ok} - {1'b0, rd};
      rdata_o <= (rd && cnt_o == 2'd2) ? tail_q : (wr_ok && (rd || cnt_o == 2'd0)) ? wdata_i : rdata_o;
      tail_q <= (wr_ok && cnt_o == (rd ? 2'd2 : 2'd1)) ? wdata_i : tail_q;
    end
  end
endmodule

// File: rtl/prim_fifo_sync_rd_ctrl.sv
// prim_fifo_sync_rd_ctrl: read-side FIFO controller popping storage into a 2-entry skid output stream
module prim_fifo_sync_rd_ctrl
  import prim_fifo_rd_pkg::*;
#(
  parameter int unsigned Width   = 8,
  parameter int unsigned Depth   = 4,
  parameter int unsigned LowMark = 1
) (
  input logic clk_i,
  input logic rst_i,
  prim_fifo_sync_rd_ctrl_if.master bus
);
  localparam int unsigned PtrW   = vbits(Depth);
  localparam int unsigned DepthW = vbits(Depth + 1);
  rd_state_e state_q, state_d;
  logic inflight_q, lowmark_q, err_q, pop, capture, drain, skid_valid;
  logic [1:0] skid_cnt;
  logic [DepthW:0] total;
  assign drain = bus.rvalid_o & bus.rready_i;
  assign total = {1'b0, bus.fifo_depth_i} + (DepthW+1)'(skid_cnt) + (DepthW+1)'(inflight_q);
  assign bus.rvalid_o = skid_valid & ~rst_i;
  assign bus.fifo_incr_rptr_o = pop;
  assign bus.mem_rd_en_o = pop;
  assign bus.mem_raddr_o = rst_i ? PtrW'(0) : bus.fifo_rptr_i;
  assign bus.lowmark_o = lowmark_q;
  assign bus.err_o = err_q;
  always_ff @(posedge clk_i) begin
    state_q <= rst_i ? RdIdle : state_d;
  end
  always_comb begin
    state_d = (state_q == RdRun && bus.clr_i && inflight_q) ? RdFlush : RdRun;
    pop = !rst_i && state_q == RdRun && !bus.fifo_empty_i && !bus.clr_i &&
          ({1'b0, skid_cnt} + {2'b0, inflight_q}) < (3'(SkidDepth) + {2'b0, drain});
    capture = !rst_i && state_q == RdRun && inflight_q && !bus.clr_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      lowmark_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      inflight_q <= pop;
      lowmark_q <= total <= (DepthW+1)'(LowMark);
      err_q <= err_q | (pop & bus.fifo_empty_i) | (capture & skid_cnt == 2'(SkidDepth) & ~drain) |
               (bus.fifo_depth_i > DepthW'(Depth));
    end
  end
  prim_skid_buf2 #(.Width(Width)) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (bus.clr_i),
    .wr_i    (capture),
    .wdata_i (bus.mem_rdata_i),
    .rready_i(bus.rready_i),
    .rvalid_o(skid_valid),
    .rdata_o (bus.rdata_o),
    .cnt_o   (skid_cnt)
  );
endmodule

// File: tb/tb_prim_fifo_sync_rd_ctrl.sv
// tb_prim_fifo_sync_rd_ctrl: scoreboard bench with a behavioural pointer counter and storage array
module tb_prim_fifo_sync_rd_ctrl;
  import prim_fifo_rd_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  prim_fifo_sync_rd_ctrl_if #(.Width(8), .PtrW(2), .DepthW(3)) bus ();
  prim_fifo_sync_rd_ctrl #(.Width(8), .Depth(4), .LowMark(1)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.master)
  );
  logic [7:0] fmem [4];
  logic [7:0] pre [4];
  logic [1:0] frptr;
  logic [2:0] fcnt, force_val, pre_n;
  logic force_en = 1'b0, load = 1'b0, clr = 1'b0, rready = 1'b0;
  logic [7:0] q[$];
  int total = 0, bad = 0;
  logic stall_q = 1'b0;
  logic [7:0] stall_data;
  assign bus.clr_i = clr;
  assign bus.rready_i = rready;
  assign bus.fifo_empty_i = fcnt == 3'd0;
  assign bus.fifo_depth_i = force_en ? force_val : fcnt;
  assign bus.fifo_rptr_i = frptr;
  always @(posedge clk) begin
    if (rst || clr) begin
      frptr <= 2'd0;
      fcnt <= 3'd0;
    end else if (load) begin
      fmem <= pre;
      frptr <= 2'd0;
      fcnt <= pre_n;
    end else if (bus.fifo_incr_rptr_o) begin
      frptr <= frptr + 2'd1;
      fcnt <= fcnt - 3'd1;
    end
    if (bus.mem_rd_en_o) bus.mem_rdata_i <= fmem[bus.mem_raddr_o];
  end

  task automatic step();
    logic [7:0] exp;
    #1;
    if (stall_q) begin
      total++;
      if (bus.rvalid_o !== 1'b1 || bus.rdata_o !== stall_data) begin
        bad++;
        $display("FAIL hold: rvalid=%b rdata=%h required rvalid=1 rdata=%h", bus.rvalid_o, bus.rdata_o, stall_data);
      end
    end
    if (bus.rvalid_o === 1'b1 && rready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: rdata=%h required no transfer", bus.rdata_o);
      end else begin
        exp = q.pop_front();
        if (bus.rdata_o !== exp) begin
          bad++;
          $display("FAIL sb_data: rdata=%h required %h", bus.rdata_o, exp);
        end
      end
    end
    stall_q = bus.rvalid_o === 1'b1 && !rready && !clr && !rst;
    stall_data = bus.rdata_o;
    @(posedge clk);
    #1;
  endtask

  task automatic load_fifo(input logic [7:0] base, input int n);
    for (int i = 0; i < 4; i++) begin
      pre[i] = base + 8'(i);
      if (i < n) q.push_back(base + 8'(i));
    end
    pre_n = 3'(n);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", bus.rvalid_o); end
    total++; if (bus.fifo_incr_rptr_o !== 1'b0) begin bad++; $display("FAIL rst_pop: got %b want 0", bus.fifo_incr_rptr_o); end
    total++; if (bus.rdata_o !== 8'h00) begin bad++; $display("FAIL rst_rdata: got %h want 00", bus.rdata_o); end
    total++; if (bus.lowmark_o !== 1'b1) begin bad++; $display("FAIL rst_lowmark: got %b want 1", bus.lowmark_o); end
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.err_o); end
    rst = 1'b0;
    step();
    step();
    total++; if (dut.state_q !== RdRun) begin bad++; $display("FAIL idle_state: got %0d want %0d", dut.state_q, RdRun); end
    total++; if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL idle_rvalid: got %b want 0", bus.rvalid_o); end
    total++; if (bus.fifo_incr_rptr_o !== 1'b0) begin bad++; $display("FAIL idle_pop: got %b want 0", bus.fifo_incr_rptr_o); end
    total++; if (bus.lowmark_o !== 1'b1) begin bad++; $display("FAIL idle_lowmark: got %b want 1", bus.lowmark_o); end
  endtask

  task automatic test_back_to_back();
    rready = 1'b1;
    load_fifo(8'hA0, 4);
    for (int k = 1; k <= 7; k++) begin
      total++;
      if (bus.fifo_incr_rptr_o !== (k <= 4)) begin
        bad++;
        $display("FAIL b2b_pop cycle %0d: got %b want %b", k, bus.fifo_incr_rptr_o, k <= 4);
      end
      total++;
      if (bus.rvalid_o !== (k >= 3 && k <= 6)) begin
        bad++;
        $display("FAIL b2b_rvalid cycle %0d: got %b want %b", k, bus.rvalid_o, k >= 3 && k <= 6);
      end
      step();
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL b2b_left: got %0d pending want 0", q.size()); end
  endtask

  task automatic test_backpressure();
    int pops = 0;
    rready = 1'b0;
    load_fifo(8'hC0, 4);
    for (int k = 0; k < 6; k++) begin
      pops += int'(bus.fifo_incr_rptr_o);
      step();
    end
    total++; if (pops != 2) begin bad++; $display("FAIL bp_pops: got %0d want 2", pops); end
    total++; if (bus.fifo_depth_i !== 3'd2) begin bad++; $display("FAIL bp_depth: got %0d want 2", bus.fifo_depth_i); end
    total++; if (bus.rvalid_o !== 1'b1 || bus.rdata_o !== 8'hC0) begin bad++; $display("FAIL bp_head: got %b/%h want 1/c0", bus.rvalid_o, bus.rdata_o); end
    total++; if (bus.lowmark_o !== 1'b0) begin bad++; $display("FAIL bp_lowmark: got %b want 0", bus.lowmark_o); end
    rready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) step();
    total++; if (q.size() != 0) begin bad++; $display("FAIL bp_drain: got %0d pending want 0", q.size()); end
    step();
    step();
    total++; if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", bus.rvalid_o); end
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL bp_err: got %b want 0", bus.err_o); end
  endtask

  task automatic test_clear();
    rready = 1'b1;
    load_fifo(8'h5A, 1);
    step();
    clr = 1'b1;
    q.delete();
    total++; if (dut.inflight_q !== 1'b1) begin bad++; $display("FAIL clr_inflight: got %b want 1", dut.inflight_q); end
    step();
    clr = 1'b0;
    total++; if (dut.state_q !== RdFlush) begin bad++; $display("FAIL clr_flush: got %0d want %0d", dut.state_q, RdFlush); end
    total++; if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL clr_rvalid: got %b want 0", bus.rvalid_o); end
    step();
    total++; if (dut.state_q !== RdRun) begin bad++; $display("FAIL clr_run: got %0d want %0d", dut.state_q, RdRun); end
    step();
    total++; if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL clr_stale: got %b want 0", bus.rvalid_o); end
    load_fifo(8'hB0, 1);
    for (int k = 0; k < 10 && q.size() > 0; k++) step();
    total++; if (q.size() != 0) begin bad++; $display("FAIL clr_new: got %0d pending want 0", q.size()); end
    step();
    step();
  endtask

  task automatic test_toggle();
    load_fifo(8'h30, 3);
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      rready = k[0];
      step();
    end
    rready = 1'b1;
    total++; if (q.size() != 0) begin bad++; $display("FAIL tog_drain: got %0d pending want 0", q.size()); end
    step();
    step();
    total++; if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL tog_dup: got %b want 0", bus.rvalid_o); end
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL tog_err: got %b want 0", bus.err_o); end
    total++; if (bus.lowmark_o !== 1'b1) begin bad++; $display("FAIL tog_lowmark: got %b want 1", bus.lowmark_o); end
  endtask

  task automatic test_depth_err();
    force_val = 3'd5;
    force_en = 1'b1;
    step();
    force_en = 1'b0;
    total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", bus.err_o); end
    step();
    step();
    total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bus.err_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", bus.err_o); end
    step();
    step();
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL err_stay0: got %b want 0", bus.err_o); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_toggle();
    test_depth_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
